// File: rtl/bcd_display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_mux
//  Description : Multiplexed 7-segment driver for packed BCD digits.
//                Scans one digit per slot of REFRESH_DIV clocks. The first
//                cycle of every slot is a blank anode guard. New values are
//                double-buffered and applied only at a frame boundary, so a
//                scan never shows a torn value. Leading zeros can be blanked,
//                and any non-decimal nibble is shown as a dash.
//  Ports       : clk      - system clock, rising edge
//                rst_n    - synchronous reset, active-low
//                bcd      - packed BCD, nibble 0 = ones
//                load     - one-cycle strobe, capture bcd into the pending buffer
//                blank_lz - blank leading zeros (sampled every cycle)
//                seg      - {g,f,e,d,c,b,a}, registered
//                an       - one-hot digit enable, registered
//                pend     - a loaded value is waiting for the frame boundary
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  pend
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     c_CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     c_IDX_MAX = IW'(DIGITS - 1);
    // XOR masks that turn the active-high internal form into pin polarity;
    // they double as the "all inactive" pin value.
    localparam logic [6:0]        c_SEG_OFF = {7{ACTIVE_LOW != 0}};
    localparam logic [DIGITS-1:0] c_AN_OFF  = {DIGITS{ACTIVE_LOW != 0}};

    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_disp;
    logic [4*DIGITS-1:0] r_pbuf;
    logic                r_pend_valid;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    logic                w_slot_end;
    logic                w_fb;
    logic [4*DIGITS-1:0] w_shift;
    logic [3:0]          w_nib;
    logic [6:0]          w_dec;
    logic                w_blank;
    logic [DIGITS-1:0]   w_onehot;
    logic [6:0]          w_seg_hi;
    logic [DIGITS-1:0]   w_an_hi;

    assign w_slot_end = (r_cnt == c_CNT_MAX);
    assign w_fb       = w_slot_end && (r_idx == c_IDX_MAX);

    // ------------------------------------------------------------------
    // Prescaler and digit scan
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + IW'(1);
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Double buffer. A load coinciding with the frame boundary bypasses
    // the pending buffer and goes straight to the display register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_disp       <= '0;
            r_pbuf       <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_fb) begin
            if (load) begin
                r_disp <= bcd;
            end else if (r_pend_valid) begin
                r_disp <= r_pbuf;
            end
            r_pend_valid <= 1'b0;
        end else if (load) begin
            r_pbuf       <= bcd;
            r_pend_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Segment decode and blanking (active-high form)
    // ------------------------------------------------------------------
    always_comb begin
        // After shifting the current digit down to bit 0, the remaining
        // vector holds exactly this digit and all more significant ones,
        // so "all zero" means the digit is a leading zero.
        w_shift  = r_disp >> {r_idx, 2'b00};
        w_nib    = w_shift[3:0];
        w_blank  = blank_lz && (r_idx != '0) && (w_shift == '0);
        w_onehot = '0;
        w_onehot[r_idx] = 1'b1;

        case (w_nib)
            4'd0:    w_dec = 7'h3F;
            4'd1:    w_dec = 7'h06;
            4'd2:    w_dec = 7'h5B;
            4'd3:    w_dec = 7'h4F;
            4'd4:    w_dec = 7'h66;
            4'd5:    w_dec = 7'h6D;
            4'd6:    w_dec = 7'h7D;
            4'd7:    w_dec = 7'h07;
            4'd8:    w_dec = 7'h7F;
            4'd9:    w_dec = 7'h6F;
            default: w_dec = 7'h40;
        endcase

        w_seg_hi = '0;
        w_an_hi  = '0;
        if (r_cnt != '0) begin
            w_an_hi  = w_onehot;
            w_seg_hi = w_blank ? 7'h00 : w_dec;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg <= c_SEG_OFF;
            r_an  <= c_AN_OFF;
        end else begin
            r_seg <= w_seg_hi ^ c_SEG_OFF;
            r_an  <= w_an_hi ^ c_AN_OFF;
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign pend = r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_display_mux
//  Description : Scoreboard bench for bcd_display_mux. Two instances share
//                all inputs, one with active-low pins and one with
//                active-high pins. A cycle-level reference model pushes the
//                expected outputs into a queue; a monitor pops one entry per
//                clock and compares both instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_mux;

    localparam int c_D = 4;
    localparam int c_R = 4;

    typedef struct packed {
        logic [6:0] seg;   // active-high form
        logic [3:0] an;    // active-high form
        logic       pend;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;

    logic [6:0]  seg_lo, seg_hi;
    logic [3:0]  an_lo, an_hi;
    logic        pend_lo, pend_hi;

    exp_t        q[$];
    int          errs = 0;
    int          chks = 0;

    // reference model state
    int          m_pos = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pbuf = '0;
    logic        m_pend = 1'b0;
    logic        r_blz = 1'b0;

    always #5 clk = ~clk;

    bcd_display_mux #(.DIGITS(c_D), .REFRESH_DIV(c_R), .ACTIVE_LOW(1)) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .blank_lz(blank_lz),
        .seg(seg_lo), .an(an_lo), .pend(pend_lo)
    );

    bcd_display_mux #(.DIGITS(c_D), .REFRESH_DIV(c_R), .ACTIVE_LOW(0)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .blank_lz(blank_lz),
        .seg(seg_hi), .an(an_hi), .pend(pend_hi)
    );

    function automatic logic [6:0] ref_seg(input int n);
        case (n)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected output after the next rising edge, then advance the model.
    // m_pos is the position within the frame (slot*R + phase).
    task automatic model_step(input logic rn, input logic ld, input logic [15:0] b,
                              input logic blz);
        exp_t e;
        int   slot;
        int   ph;
        logic [15:0] upper;
        e = '0;
        if (!rn) begin
            m_pos  = 0;
            m_disp = '0;
            m_pbuf = '0;
            m_pend = 1'b0;
        end else begin
            slot  = m_pos / c_R;
            ph    = m_pos % c_R;
            upper = m_disp >> (4 * slot);
            if (ph != 0) begin
                e.an = 4'(1 << slot);
                if (!(blz && slot > 0 && upper == 16'h0))
                    e.seg = ref_seg(int'(upper & 16'hF));
            end
            if (m_pos == c_D * c_R - 1) begin
                if (ld)          m_disp = b;
                else if (m_pend) m_disp = m_pbuf;
                m_pend = 1'b0;
            end else if (ld) begin
                m_pbuf = b;
                m_pend = 1'b1;
            end
            m_pos = (m_pos + 1) % (c_D * c_R);
        end
        e.pend = m_pend;
        q.push_back(e);
    endtask

    task automatic drive(input logic rn, input logic ld, input logic [15:0] b);
        @(negedge clk);
        rst_n    = rn;
        load     = ld;
        bcd      = b;
        blank_lz = r_blz;
        model_step(rn, ld, b, r_blz);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 16'h0);
    endtask

    task automatic wait_pos(input int p);
        for (int k = 0; k < 2 * c_D * c_R && m_pos != p; k++) drive(1'b1, 1'b0, 16'h0);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        int r;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 15);
            if (r < 5)       v[4*i +: 4] = 4'd0;
            else if (r < 14) v[4*i +: 4] = 4'($urandom_range(1, 9));
            else             v[4*i +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    // monitor: one expected entry per clock once stimulus has started
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chks++;
            if (seg_lo !== ~e.seg || an_lo !== ~e.an || pend_lo !== e.pend) begin
                errs++;
                $display("FAIL out_lo t=%0t: got seg=%h an=%h pend=%b exp seg=%h an=%h pend=%b",
                         $time, seg_lo, an_lo, pend_lo, ~e.seg, ~e.an, e.pend);
            end
            chks++;
            if (seg_hi !== e.seg || an_hi !== e.an || pend_hi !== e.pend) begin
                errs++;
                $display("FAIL out_hi t=%0t: got seg=%h an=%h pend=%b exp seg=%h an=%h pend=%b",
                         $time, seg_hi, an_hi, pend_hi, e.seg, e.an, e.pend);
            end
        end
    end

    initial begin
        // reset, then idle frame showing zeros
        drive(1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 16'h0);
        idle(16);

        // load mid-frame: pending until the boundary
        wait_pos(5);
        drive(1'b1, 1'b1, 16'h8191);
        idle(32);

        // leading-zero blanking
        r_blz = 1'b1;
        drive(1'b1, 1'b1, 16'h0042);
        idle(32);
        drive(1'b1, 1'b1, 16'h0000);
        idle(32);
        r_blz = 1'b0;

        // load on the frame-boundary cycle, then last-load-wins
        wait_pos(15);
        drive(1'b1, 1'b1, 16'h1234);
        idle(32);
        wait_pos(2);
        drive(1'b1, 1'b1, 16'h1111);
        wait_pos(7);
        drive(1'b1, 1'b1, 16'h2222);
        idle(32);

        // invalid nibble with blanking
        r_blz = 1'b1;
        drive(1'b1, 1'b1, 16'h00A5);
        idle(32);
        r_blz = 1'b0;

        // reset during digit 2 with a pending value
        wait_pos(3);
        drive(1'b1, 1'b1, 16'h9876);
        wait_pos(9);
        drive(1'b0, 1'b0, 16'h0);
        idle(24);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) r_blz = ~r_blz;
            if ($urandom_range(0, 399) == 0)
                drive(1'b0, 1'($urandom_range(0, 1)), rand_bcd());
            else
                drive(1'b1, ($urandom_range(0, 7) == 0), rand_bcd());
        end

        @(posedge clk);
        #3;
        chks++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d entries left, exp 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
`default_nettype wire
